// File: rtl/bt_msg_pkg.sv
// ---------------------------------------------------------------------------
// bt_msg_pkg
//
// Shared definitions for the Bluetooth message scheduler:
//   - MSG_END terminator byte ('#'), sent as the last byte of a message
//   - FSM state enum used by the scheduler (IDLE, LOAD, SEND, DONE)
//   - fixed slot assignments for the on-bot message sources
//   - the message text of every slot and a lookup helper used by the ROM
// ---------------------------------------------------------------------------
package bt_msg_pkg;

  localparam logic [7:0] MSG_END = 8'h23;

  localparam int MSG_SLOTS = 4;
  localparam int MSG_BYTES = 16;
  localparam int MSG_IDX_W = $clog2(MSG_BYTES);

  localparam int SLOT_FAULT = 0;
  localparam int SLOT_NODE  = 1;
  localparam int SLOT_END   = 2;
  localparam int SLOT_SPARE = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;

  // The first character sits in the most significant byte, so element
  // [MSG_BYTES-1] is byte 0 of the message. Shorter texts are zero padded.
  typedef logic [MSG_BYTES-1:0][7:0] msg_text_t;

  localparam msg_text_t MSG_FAULT_TEXT = {"FIM-CSU1-#", 48'h0};
  localparam msg_text_t MSG_NODE_TEXT  = {"NODE-ARRIVED-#", 16'h0};
  localparam msg_text_t MSG_END_TEXT   = {"END-OF-RUN-#", 32'h0};
  // The spare slot deliberately has no terminator; it is cut off after
  // MSG_BYTES bytes by the length limit in the scheduler.
  localparam msg_text_t MSG_SPARE_TEXT = "SPARE-SLOT-NO-TM";

  // Byte idx of the message in the given slot; unknown slots and indices
  // beyond the table read as 0.
  function automatic logic [7:0] msg_byte(input int slot, input int idx);
    msg_text_t            text;
    logic [MSG_IDX_W-1:0] pos;
    case (slot)
      SLOT_FAULT: text = MSG_FAULT_TEXT;
      SLOT_NODE:  text = MSG_NODE_TEXT;
      SLOT_END:   text = MSG_END_TEXT;
      SLOT_SPARE: text = MSG_SPARE_TEXT;
      default:    text = '0;
    endcase
    if (idx < 0 || idx >= MSG_BYTES) begin
      return 8'h00;
    end
    pos = MSG_IDX_W'(MSG_BYTES - 1 - idx);
    return text[pos];
  endfunction

endpackage

// File: rtl/bt_msg_rom.sv
// ---------------------------------------------------------------------------
// bt_msg_rom
//
// NUM_SLOTS x MSG_LEN x 8 message ROM with a registered (synchronous) read,
// contents taken from bt_msg_pkg. The output register only loads when
// rd_en is high, so the byte stays put while the consumer stalls.
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset (clears the read register)
//   rd_en    in   load the output register from rd_addr this cycle
//   rd_addr  in   {slot, char_idx}
//   rd_data  out  registered ROM byte
// ---------------------------------------------------------------------------
module bt_msg_rom
  import bt_msg_pkg::*;
#(
  parameter int  NUM_SLOTS = MSG_SLOTS,
  parameter int  MSG_LEN   = MSG_BYTES,
  localparam int SLOT_W    = $clog2(NUM_SLOTS),
  localparam int IDX_W     = $clog2(MSG_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_en,
  input  logic [SLOT_W+IDX_W-1:0] rd_addr,
  output logic [7:0]              rd_data
);

  logic [7:0] rd_data_q;
  logic [7:0] rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = msg_byte(int'(rd_addr[SLOT_W+IDX_W-1:IDX_W]),
                           int'(rd_addr[IDX_W-1:0]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/bt_msg_scheduler.sv
// ---------------------------------------------------------------------------
// bt_msg_scheduler
//
// Shares the single Bluetooth UART transmitter between several message
// sources. One-cycle requests are latched into a pending register, a
// round-robin arbiter picks the next slot, and the slot's message is read
// byte by byte from bt_msg_rom and handed to the UART over valid/ready.
// A message ends on the '#' terminator (which is sent) or after
// MSG_LEN_MAX bytes.
//
// Optional feature, macro BT_MSG_TIMEOUT_EN: a stall counter aborts a
// message after TIMEOUT_CYC consecutive SEND cycles without tx_ready and
// pulses err. Without the macro SEND waits forever and err is tied low.
//
// Ports:
//   clk_50M   in   system clock
//   rst       in   asynchronous active-high reset
//   req       in   per-slot request pulses
//   tx_ready  in   UART TX accepts a byte this cycle
//   tx_data   out  byte to the UART, held while tx_valid && !tx_ready
//   tx_valid  out  tx_data is valid
//   busy      out  a message is in progress (FSM not in IDLE)
//   grant_id  out  slot currently being sent
//   done      out  one-cycle pulse for the slot whose last byte transferred
//   err       out  one-cycle pulse on a timeout abort
// ---------------------------------------------------------------------------
module bt_msg_scheduler
  import bt_msg_pkg::*;
#(
  parameter int  NUM_REQ     = MSG_SLOTS,
  parameter int  MSG_LEN_MAX = MSG_BYTES,
`ifdef BT_MSG_TIMEOUT_EN
  parameter int  TIMEOUT_CYC = 5_000_000,
`endif
  localparam int GNT_W       = $clog2(NUM_REQ),
  localparam int IDX_W       = $clog2(MSG_LEN_MAX)
) (
  input  logic               clk_50M,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               tx_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  output logic               busy,
  output logic [GNT_W-1:0]   grant_id,
  output logic [NUM_REQ-1:0] done,
  output logic               err
);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [GNT_W-1:0]   grant_q, grant_d;
  logic [GNT_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   char_idx_q, char_idx_d;

  logic [NUM_REQ-1:0] pend_clr;
  logic [NUM_REQ-1:0] done_pulse;
  logic               rom_rd_en;
  logic [7:0]         rom_data;
  logic               arb_found;
  logic [GNT_W-1:0]   arb_winner;
  logic [GNT_W-1:0]   arb_cand;
  logic               xfer;
  logic               last_byte;

`ifdef BT_MSG_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               timeout_abort;
`endif

  bt_msg_rom #(
    .NUM_SLOTS (NUM_REQ),
    .MSG_LEN   (MSG_LEN_MAX)
  ) u_rom (
    .clk     (clk_50M),
    .rst     (rst),
    .rd_en   (rom_rd_en),
    .rd_addr ({grant_q, char_idx_q}),
    .rd_data (rom_data)
  );

  // Round-robin search: start just after the last granted slot and wrap,
  // so a slot that was just served has the lowest priority next time.
  always_comb begin
    arb_found  = 1'b0;
    arb_winner = '0;
    arb_cand   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      arb_cand = GNT_W'((int'(last_grant_q) + i) % NUM_REQ);
      if (!arb_found && pend_q[arb_cand]) begin
        arb_found  = 1'b1;
        arb_winner = arb_cand;
      end
    end
  end

  assign xfer      = (state_q == SEND) && tx_ready;
  assign last_byte = (rom_data == MSG_END) ||
                     (char_idx_q == IDX_W'(MSG_LEN_MAX - 1));

  // Next-state logic. The pending bit of a slot is cleared in the cycle it
  // is granted; a request arriving in that same cycle, or any later
  // request while the slot is being sent, sets it again so the message
  // repeats afterwards.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    char_idx_d   = char_idx_q;
    pend_clr     = '0;
    done_pulse   = '0;
    rom_rd_en    = 1'b0;
`ifdef BT_MSG_TIMEOUT_EN
    stall_d       = stall_q;
    timeout_abort = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d            = arb_winner;
          last_grant_d       = arb_winner;
          char_idx_d         = '0;
          pend_clr[arb_winner] = 1'b1;
          state_d            = LOAD;
        end
      end

      LOAD: begin
        rom_rd_en = 1'b1;
        state_d   = SEND;
      end

      SEND: begin
        if (xfer) begin
`ifdef BT_MSG_TIMEOUT_EN
          stall_d = '0;
`endif
          if (last_byte) begin
            state_d = DONE;
          end else begin
            char_idx_d = char_idx_q + IDX_W'(1);
            state_d    = LOAD;
          end
        end else begin
`ifdef BT_MSG_TIMEOUT_EN
          // The abort fires on the TIMEOUT_CYC-th consecutive stalled cycle.
          // Pending bits are left alone; the aborted slot is not re-queued.
          if (stall_q == STALL_W'(TIMEOUT_CYC - 1)) begin
            timeout_abort = 1'b1;
            stall_d       = '0;
            state_d       = IDLE;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
`endif
        end
      end

      DONE: begin
        done_pulse[grant_q] = 1'b1;
        state_d             = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    pend_d = (pend_q & ~pend_clr) | req;
  end

  // Everything clears asynchronously, so a reset abandons any partial
  // message and forgets all pending requests.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      grant_q      <= '0;
      last_grant_q <= GNT_W'(NUM_REQ - 1);
      char_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      char_idx_q   <= char_idx_d;
    end
  end

`ifdef BT_MSG_TIMEOUT_EN
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign err = timeout_abort;
`else
  assign err = 1'b0;
`endif

  assign tx_valid = (state_q == SEND);
  assign tx_data  = rom_data;
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;
  assign done     = done_pulse;

endmodule

// File: tb/tb_bt_msg_scheduler.sv
// Self-checking bench for bt_msg_scheduler. Expected bytes and done pulses
// are pushed into queues when requests are issued and popped by a monitor
// when the DUT transfers a byte or pulses done.
module tb_bt_msg_scheduler;

  localparam int NUM_REQ     = 4;
  localparam int MSG_LEN_MAX = 16;

  logic               clk_50M = 1'b0;
  logic               rst;
  logic [NUM_REQ-1:0] req;
  logic               tx_ready;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               busy;
  logic [1:0]         grant_id;
  logic [NUM_REQ-1:0] done;
  logic               err;

  typedef struct packed {
    logic [1:0] slot;
    logic [7:0] data;
  } expByte_t;

  typedef struct {
    logic [3:0] reqMask;
    bit         randReady;
    int         expBytes;
  } vec_t;

  expByte_t   expQ[$];
  int         doneQ[$];
  vec_t       vecs[6];
  int         total = 0;
  int         bad = 0;
  int         xferCount = 0;
  int         errCount = 0;
  int         doneCount[NUM_REQ];
  int         readyMode = 0;
  bit         manualReady = 1'b1;
  int         modelLast = NUM_REQ - 1;
  logic       prevStall = 1'b0;
  logic [7:0] prevData = 8'h00;

  bt_msg_scheduler #(
    .NUM_REQ     (NUM_REQ),
    .MSG_LEN_MAX (MSG_LEN_MAX)
`ifdef BT_MSG_TIMEOUT_EN
    , .TIMEOUT_CYC (100)
`endif
  ) dut (
    .clk_50M  (clk_50M),
    .rst      (rst),
    .req      (req),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .busy     (busy),
    .grant_id (grant_id),
    .done     (done),
    .err      (err)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic string msgText(input int slot);
    case (slot)
      0:       return "FIM-CSU1-#";
      1:       return "NODE-ARRIVED-#";
      2:       return "END-OF-RUN-#";
      default: return "SPARE-SLOT-NO-TM";
    endcase
  endfunction

  task automatic pushMessage(input int slot);
    string    s;
    expByte_t e;
    s = msgText(slot);
    for (int i = 0; i < MSG_LEN_MAX && i < s.len(); i++) begin
      e.slot = 2'(slot);
      e.data = s[i];
      expQ.push_back(e);
      if (s[i] == "#") break;
    end
    doneQ.push_back(slot);
  endtask

  // Model of the arbitration order for requests that all arrive while idle.
  task automatic pushRoundRobin(input logic [3:0] mask);
    int start;
    int s;
    start = modelLast;
    for (int k = 1; k <= NUM_REQ; k++) begin
      s = (start + k) % NUM_REQ;
      if (mask[s]) begin
        pushMessage(s);
        modelLast = s;
      end
    end
  endtask

  task automatic applyStimulus(input logic [3:0] mask);
    @(posedge clk_50M); #1;
    req = mask;
    @(posedge clk_50M); #1;
    req = '0;
  endtask

  task automatic waitDrain(input string name, input int budget);
    bit drained;
    drained = 1'b0;
    for (int k = 0; k < budget && !drained; k++) begin
      @(negedge clk_50M); #1;
      if (expQ.size() == 0 && doneQ.size() == 0 && !busy) drained = 1'b1;
    end
    checkOutput(name, 32'(drained), 1);
    if (!drained) begin
      expQ.delete();
      doneQ.delete();
    end
  endtask

  task automatic waitXfers(input string name, input int target, input int budget);
    bit reached;
    reached = 1'b0;
    for (int k = 0; k < budget && !reached; k++) begin
      @(negedge clk_50M); #1;
      if (xferCount >= target) reached = 1'b1;
    end
    checkOutput(name, 32'(reached), 1);
  endtask

  // tx_ready driver: always ready, random, or under manual control.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk_50M); #1;
      if (readyMode == 0)      tx_ready = 1'b1;
      else if (readyMode == 1) tx_ready = 1'($urandom_range(0, 1));
      else                     tx_ready = manualReady;
    end
  end

  // Monitor: transfers pop the byte queue, done pulses pop the done queue,
  // and a stalled byte must not change.
  initial begin
    expByte_t e;
    for (int i = 0; i < NUM_REQ; i++) doneCount[i] = 0;
    forever begin
      @(negedge clk_50M);
      if (rst) begin
        prevStall = 1'b0;
      end else begin
        if (tx_valid && prevStall) checkOutput("hold_data", tx_data, prevData);
        if (tx_valid && tx_ready) begin
          xferCount++;
          if (expQ.size() == 0) begin
            checkOutput("unexpected_byte", tx_data, 32'hFFFF_FFFF);
          end else begin
            e = expQ.pop_front();
            checkOutput("byte", tx_data, e.data);
            checkOutput("grant_id", grant_id, e.slot);
          end
        end
        if (done != '0) begin
          for (int i = 0; i < NUM_REQ; i++) if (done[i]) doneCount[i]++;
          if (doneQ.size() == 0) checkOutput("unexpected_done", done, 0);
          else checkOutput("done_onehot", done, 32'(1) << doneQ.pop_front());
        end
        if (err) errCount++;
        prevStall = tx_valid && !tx_ready;
        prevData  = tx_data;
      end
    end
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  base;
    int  dbase;
    int  lat;
    int  cnt;
    bit  seen;

    rst = 1'b1;
    req = '0;

    vecs[0] = '{4'b1000, 1'b0, 16};
    vecs[1] = '{4'b0101, 1'b0, 22};
    vecs[2] = '{4'b0110, 1'b1, 26};
    vecs[3] = '{4'b1111, 1'b1, 52};
    vecs[4] = '{4'b0010, 1'b1, 14};
    vecs[5] = '{4'b0001, 1'b0, 10};

    // Reset state
    repeat (3) @(posedge clk_50M);
    #3;
    checkOutput("rst_tx_data", tx_data, 0);
    checkOutput("rst_tx_valid", tx_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_grant_id", grant_id, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    @(negedge clk_50M);
    rst = 1'b0;

    // Single request: latency and message content
    $display("[TB] single request slot 0");
    readyMode = 0;
    base  = xferCount;
    dbase = doneCount[0];
    pushRoundRobin(4'b0001);
    applyStimulus(4'b0001);
    lat  = 0;
    seen = 1'b0;
    for (int k = 1; k <= 10 && !seen; k++) begin
      @(negedge clk_50M);
      if (tx_valid) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    checkOutput("first_valid_latency", lat, 3);
    waitDrain("single_drain", 200);
    checkOutput("single_bytes", xferCount - base, 10);
    checkOutput("single_done_count", doneCount[0] - dbase, 1);

    // Table-driven request patterns
    foreach (vecs[v]) begin
      $display("[TB] vector %0d req=%b", v, vecs[v].reqMask);
      base      = xferCount;
      readyMode = vecs[v].randReady ? 1 : 0;
      pushRoundRobin(vecs[v].reqMask);
      applyStimulus(vecs[v].reqMask);
      waitDrain("vec_drain", 1500);
      checkOutput("vec_bytes", xferCount - base, vecs[v].expBytes);
    end

    // Backpressure: 20 stalled cycles in the middle of slot 2
    $display("[TB] backpressure");
    readyMode   = 2;
    manualReady = 1'b1;
    base        = xferCount;
    pushRoundRobin(4'b0100);
    applyStimulus(4'b0100);
    waitXfers("bp_reach", base + 4, 100);
    manualReady = 1'b0;
    @(posedge clk_50M); #1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk_50M);
      if (tx_valid) seen = 1'b1;
    end
    cnt = 0;
    repeat (20) begin
      @(negedge clk_50M);
      if (tx_valid && !tx_ready) cnt++;
    end
    checkOutput("bp_valid_held", cnt, 20);
    manualReady = 1'b1;
    waitDrain("bp_drain", 200);
    checkOutput("bp_bytes", xferCount - base, 12);
    readyMode = 0;

    // Re-request of the slot being sent
    $display("[TB] re-request during send");
    base  = xferCount;
    dbase = doneCount[1];
    pushRoundRobin(4'b0010);
    pushMessage(1);
    applyStimulus(4'b0010);
    waitXfers("rereq_reach", base + 4, 100);
    applyStimulus(4'b0010);
    waitDrain("rereq_drain", 300);
    checkOutput("rereq_done_count", doneCount[1] - dbase, 2);
    checkOutput("rereq_bytes", xferCount - base, 28);

    // Reset in the middle of a message, with slot 2 also pending
    $display("[TB] reset mid-message");
    base = xferCount;
    pushRoundRobin(4'b0001);
    applyStimulus(4'b0001);
    applyStimulus(4'b0100);
    waitXfers("rstmid_reach", base + 3, 100);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk_50M); #1;
      if (tx_valid) seen = 1'b1;
    end
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_tx_valid", tx_valid, 0);
    checkOutput("rstmid_busy", busy, 0);
    checkOutput("rstmid_tx_data", tx_data, 0);
    expQ.delete();
    doneQ.delete();
    modelLast = NUM_REQ - 1;
    @(negedge clk_50M);
    rst  = 1'b0;
    base = xferCount;
    cnt  = 0;
    repeat (30) begin
      @(negedge clk_50M);
      if (busy || tx_valid) cnt++;
    end
    checkOutput("rstmid_no_resume", cnt, 0);
    checkOutput("rstmid_no_bytes", xferCount - base, 0);

`ifdef BT_MSG_TIMEOUT_EN
    // Timeout abort after 100 stalled SEND cycles
    $display("[TB] timeout abort");
    readyMode   = 2;
    manualReady = 1'b0;
    base  = xferCount;
    dbase = doneCount[0];
    modelLast = 0;
    applyStimulus(4'b0001);
    cnt  = 0;
    lat  = 0;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk_50M); #1;
      if (tx_valid && !tx_ready) cnt++;
      if (err) begin
        seen = 1'b1;
        lat  = cnt;
      end
    end
    checkOutput("timeout_stall_cycle", lat, 100);
    repeat (2) @(negedge clk_50M);
    checkOutput("timeout_busy", busy, 0);
    checkOutput("timeout_tx_valid", tx_valid, 0);
    manualReady = 1'b1;
    repeat (20) @(negedge clk_50M);
    checkOutput("timeout_no_done", doneCount[0] - dbase, 0);
    checkOutput("timeout_no_bytes", xferCount - base, 0);
    checkOutput("err_pulses", errCount, 1);
`else
    checkOutput("err_pulses", errCount, 0);
`endif

    checkOutput("final_queue_empty", expQ.size() + doneQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bt_msg_scheduler.md
# bt_msg_scheduler

Shares the single Bluetooth UART transmitter between several on-bot message sources (fault detection, node arrival, end-of-run). Each source raises a one-cycle request for its fixed message slot. The scheduler latches and round-robin arbitrates the requests, fetches the chosen message byte by byte from a message ROM, and hands each byte to the UART transmitter over a valid/ready handshake. It sits between the detection/navigation blocks and the UART TX.

## Interface
- NUM_REQ, 4: number of requesters, which is also the number of message slots.
- MSG_LEN_MAX, 16: bytes per slot; the slot address is {slot, char_idx}.
- MSG_END, 8'h23: terminator byte `#`. It is transmitted, and it ends the message.
- TIMEOUT_CYC, 5_000_000: stall limit in cycles. Used only with BT_MSG_TIMEOUT_EN.
- clk_50M  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-slot request pulse; any high cycle counts.
- tx_ready  in  1  UART TX can accept a byte this cycle.
- tx_data  out  8  byte to the UART; stable while tx_valid is high.
- tx_valid  out  1  tx_data is valid.
- busy  out  1  a message is in progress (state is not IDLE).
- grant_id  out  $clog2(NUM_REQ)  slot currently being sent.
- done  out  NUM_REQ  one-cycle pulse for the slot whose final byte transferred.
- err  out  1  one-cycle pulse on timeout abort. Tied 0 without the macro.

## Operation
- Pending register `pend[NUM_REQ]`:
  - Set by `req`.
  - Cleared for a slot on the cycle that slot is granted.
  - A request for an already-pending slot merges into it; the message is sent once.
  - A request for the slot currently being sent sets pend again, so the message repeats afterwards.
- Round-robin arbitration over `pend`. The search starts at `last_grant+1` and wraps. After reset, `last_grant` = NUM_REQ-1, so slot 0 has first priority.
- FSM states:
  - IDLE: on `pend != 0`, grant the winner, set char_idx=0, go to LOAD.
  - LOAD: present ROM address {grant_id, char_idx}, go to SEND.
  - SEND: `tx_valid`=1, `tx_data`=ROM output. Hold until `tx_valid && tx_ready`.
  - On a transfer in SEND:
    - If the byte == MSG_END or char_idx == MSG_LEN_MAX-1: go to DONE.
    - Otherwise char_idx+1 and go to LOAD.
  - DONE: pulse `done[grant_id]`, go to IDLE.
- char_idx is $clog2(MSG_LEN_MAX) bits wide and never wraps. A slot with no terminator is cut off after MSG_LEN_MAX bytes and still reports done.
- Reset mid-message: every register clears immediately and asynchronously, tx_valid drops, the partial message is abandoned and is not resumed.
- Reset values:
  - tx_data=0, tx_valid=0, busy=0, grant_id=0, done=0, err=0.
  - pend=0, state=IDLE.

## Timing
- req high in cycle N → pend set at edge N+1 → IDLE→LOAD at edge N+2 → tx_valid high from cycle N+3.
- ROM read latency is 1 cycle (synchronous read, registered address in LOAD).
- Byte throughput: at most 1 byte per 2 cycles (a LOAD bubble precedes each byte). This is far above the UART byte rate.
- done pulses the cycle after the final transfer. busy deasserts in the same cycle the FSM re-enters IDLE.
- Back-to-back messages: if pend is nonzero in IDLE, the next grant is taken on the first IDLE cycle, with no extra idle cycle.
- tx_data must not change while tx_valid=1 and tx_ready=0.

## Configuration
- Macro: BT_MSG_TIMEOUT_EN.
- Defined:
  - A stall counter counts SEND cycles with tx_ready=0, and clears on every transfer.
  - When the counter reaches TIMEOUT_CYC-1: abort the message, pulse err, drop tx_valid, go to IDLE. No done pulse is issued. pend bits stay as they are.
- Undefined:
  - No counter exists. SEND waits indefinitely and err is constant 0.

## Structure
- Package `bt_msg_pkg` holds:
  - the MSG_END constant;
  - the FSM state enum (IDLE, LOAD, SEND, DONE);
  - the slot assignments: SLOT_FAULT=0, SLOT_NODE=1, SLOT_END=2, SLOT_SPARE=3;
  - the slot message contents, e.g. slot 0 = "FIM-CSU1-#".
- Sub-module `bt_msg_rom`: NUM_REQ×MSG_LEN_MAX×8 synchronous-read ROM, initialised from the package contents.

## Test plan
- Single request: pulse req[0] with tx_ready held at 1 → bytes 46,49,4D,2D,43,53,55,31,2D,23 on consecutive valid cycles, then done[0] pulses once. First tx_valid is 3 cycles after the req pulse.
- Simultaneous requests: req=4'b0101 in the same cycle → slot 0 is sent completely, then slot 2. grant_id reads 0 then 2, and the messages do not interleave.
- Backpressure: hold tx_ready low for 20 cycles in the middle of a byte → tx_valid stays 1 and tx_data stays stable. On release the byte transfers exactly once.
- Re-request during send: pulse req[1] while slot 1 is being sent → slot 1 is sent twice in total and done[1] pulses twice.
- Reset mid-message: assert rst after the 3rd byte → tx_valid, busy and pend fall to 0 without waiting for a clock edge. After release, with no new request, nothing is sent.
- With BT_MSG_TIMEOUT_EN and TIMEOUT_CYC=100: hold tx_ready at 0 → err pulses at stall cycle 100, the FSM returns to IDLE, and there is no done pulse.
